// File: rtl/seq_detect_moore_prog.sv
// seq_detect_moore_prog
//   Programmable-pattern Moore sequence detector on a 1-bit serial input.
//   The pattern, its length and the overlap mode are loaded at run time via
//   cfg_load. y is a registered Moore output (high while in MATCH).
//
//   Optional feature macro: SEQDET_MATCH_CNT_EN
//     defined   -> saturating CW-bit count of hits on match_cnt
//     undefined -> no counter flops, match_cnt tied to 0
//
// Ports
//   clk          in  1   clock, rising edge
//   reset        in  1   asynchronous, active-high; clears all state
//   en           in  1   serial bit valid (a sampled only when en=1)
//   a            in  1   serial data bit
//   cfg_load     in  1   load configuration on this edge (wins over en)
//   cfg_pattern  in  PW  pattern; bit len-1 is the first bit received
//   cfg_len      in  LW  pattern length; 0 -> 1, >PW -> PW
//   cfg_overlap  in  1   1 = overlapping, 0 = non-overlapping detection
//   y            out 1   match flag
//   match_cnt    out CW  saturating match count
module seq_detect_moore_prog #(
  parameter  int PW = 8,
  parameter  int CW = 8,
  localparam int LW = $clog2(PW + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          a,
  input  logic          cfg_load,
  input  logic [PW-1:0] cfg_pattern,
  input  logic [LW-1:0] cfg_len,
  input  logic          cfg_overlap,
  output logic          y,
  output logic [CW-1:0] match_cnt
);

  typedef enum logic [1:0] {IDLE, HUNT, MATCH} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] hist_q, hist_d;
  logic [LW-1:0] fill_q, fill_d;
  logic [PW-1:0] pat_q, pat_d;
  logic [LW-1:0] len_q, len_d;
  logic          ovl_q, ovl_d;

  logic [PW-1:0] hist_n;
  logic [LW-1:0] fill_n;
  logic [PW-1:0] len_mask;
  logic          accept;
  logic          hit;

  function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] l);
    if (l == '0)
      return LW'(1);
    else if (int'(l) > PW)
      return LW'(PW);
    else
      return l;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      hist_q  <= '0;
      fill_q  <= '0;
      pat_q   <= '0;
      len_q   <= LW'(1);
      ovl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
    end
  end

  // A bit is only taken when configured and no reload is happening this edge.
  assign accept = en && !cfg_load && (state_q != IDLE);
  assign hist_n = {hist_q[PW-2:0], a};
  assign fill_n = (int'(fill_q) >= PW) ? fill_q : fill_q + LW'(1);

  // Only the low len bits of history and pattern take part in the compare.
  always_comb begin
    len_mask = '0;
    for (int i = 0; i < PW; i++)
      len_mask[i] = (i < int'(len_q));
  end

  assign hit = (fill_n >= len_q) && (((hist_n ^ pat_q) & len_mask) == '0);

  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    if (cfg_load) begin
      pat_d   = cfg_pattern;
      len_d   = clamp_len(cfg_len);
      ovl_d   = cfg_overlap;
      hist_d  = '0;
      fill_d  = '0;
      state_d = HUNT;
    end else if (accept) begin
      hist_d = hist_n;
      if (hit) begin
        state_d = MATCH;
        // Non-overlapping mode forgets the matched bits so the next match
        // needs len fresh bits; history itself keeps shifting.
        fill_d  = ovl_q ? fill_n : '0;
      end else begin
        state_d = HUNT;
        fill_d  = fill_n;
      end
    end
  end

  assign y = (state_q == MATCH);

`ifdef SEQDET_MATCH_CNT_EN
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (cfg_load)
      cnt_d = '0;
    else if (accept && hit && (cnt_q != '1))
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign match_cnt = cnt_q;
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detect_moore_prog.sv
// Testbench for seq_detect_moore_prog: directed serial streams with a
// queue-based reference model checked every cycle, plus literal checks.
module tb_seq_detect_moore_prog;

  localparam int PW = 8;
  localparam int CW = 2;
  localparam int LW = $clog2(PW + 1);
`ifdef SEQDET_MATCH_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          en = 1'b0;
  logic          a = 1'b0;
  logic          cfg_load = 1'b0;
  logic [PW-1:0] cfg_pattern = '0;
  logic [LW-1:0] cfg_len = '0;
  logic          cfg_overlap = 1'b0;
  logic          y;
  logic [CW-1:0] match_cnt;

  int tests = 0;
  int fails = 0;

  seq_detect_moore_prog #(.PW(PW), .CW(CW)) dut (
    .clk(clk), .reset(reset), .en(en), .a(a), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .y(y), .match_cnt(match_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: the list of bits received since the last (re)start.
  // A hit is "the most recent len bits read as the pattern, first bit first".
  bit            m_cfg;
  logic [PW-1:0] m_pat;
  int            m_len;
  bit            m_ovl;
  int            m_q[$];
  bit            m_y;
  int            m_cnt;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cfg = 0; m_pat = '0; m_len = 1; m_ovl = 0;
      m_q.delete(); m_y = 0; m_cnt = 0;
    end else if (cfg_load) begin
      m_cfg = 1;
      m_pat = cfg_pattern;
      m_len = (cfg_len == 0) ? 1 : ((int'(cfg_len) > PW) ? PW : int'(cfg_len));
      m_ovl = cfg_overlap;
      m_q.delete(); m_y = 0; m_cnt = 0;
    end else if (m_cfg && en) begin
      bit h;
      m_q.push_back(int'(a));
      if (m_q.size() > PW) void'(m_q.pop_front());
      h = (m_q.size() >= m_len);
      if (h)
        for (int k = 0; k < m_len; k++)
          if (m_q[m_q.size() - m_len + k] != int'(m_pat[m_len - 1 - k])) h = 0;
      m_y = h;
      if (h) begin
        if (m_cnt < (1 << CW) - 1) m_cnt++;
        if (!m_ovl) m_q.delete();
      end
    end
  end

  always @(negedge clk) begin
    int exp_cnt;
    exp_cnt = CNT_EN ? m_cnt : 0;
    tests++;
    if (y !== m_y) begin
      fails++;
      $display("FAIL model_y t=%0t actual=%b required=%b", $time, y, m_y);
    end
    tests++;
    if (int'(match_cnt) !== exp_cnt) begin
      fails++;
      $display("FAIL model_cnt t=%0t actual=%0d required=%0d", $time, match_cnt, exp_cnt);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_bit(input logic b);
    en = 1'b1; a = b;
    tick();
    en = 1'b0;
  endtask

  task automatic load(input logic [PW-1:0] p, input logic [LW-1:0] l, input logic o);
    cfg_load = 1'b1; cfg_pattern = p; cfg_len = l; cfg_overlap = o;
    tick();
    cfg_load = 1'b0;
  endtask

  // Send bits (MSB of the vector first) and check y after each one.
  task automatic send_seq(input string name, input int n, input logic [15:0] bits,
                          input logic [15:0] yexp);
    for (int i = n - 1; i >= 0; i--) begin
      send_bit(bits[i]);
      check($sformatf("%s_y%0d", name, n - i), int'(y), int'(yexp[i]));
    end
  endtask

  initial begin
    tick(); tick();
    check("reset_y", int'(y), 0);
    check("reset_cnt", int'(match_cnt), 0);
    reset = 1'b0;
    tick();

    // Unconfigured: bits are ignored.
    send_seq("idle", 4, 16'b1010, 16'b0000);

    // 1) overlapping 1010
    load(8'b1010, 4'd4, 1'b1);
    check("load_y", int'(y), 0);
    send_seq("t1", 6, 16'b101010, 16'b000101);
    check("t1_cnt", int'(match_cnt), CNT_EN ? 2 : 0);

    // 2) non-overlapping 1010
    load(8'b1010, 4'd4, 1'b0);
    send_seq("t2", 8, 16'b10101010, 16'b00010001);
    check("t2_cnt", int'(match_cnt), CNT_EN ? 2 : 0);

    // 3) overlapping 11, back-to-back
    load(8'b11, 4'd2, 1'b1);
    send_seq("t3", 3, 16'b111, 16'b011);
    check("t3_cnt", int'(match_cnt), CNT_EN ? 2 : 0);

    // 4) MATCH holds across idle cycles
    repeat (5) tick();
    check("t4_hold", int'(y), 1);
    send_seq("t4", 1, 16'b0, 16'b0);

    // 5) reload wins over a simultaneous bit
    load(8'b1010, 4'd4, 1'b1);
    send_seq("t5a", 3, 16'b101, 16'b000);
    en = 1'b1; a = 1'b0;
    load(8'b1010, 4'd4, 1'b1);
    en = 1'b0;
    check("t5_load_y", int'(y), 0);
    send_seq("t5b", 4, 16'b1010, 16'b0001);

    // 6) async reset during MATCH
    reset = 1'b1;
    #1;
    check("t6_rst_y", int'(y), 0);
    tick();
    reset = 1'b0;
    send_seq("t6", 4, 16'b1010, 16'b0000);

    // 7) length clamping
    load(8'h01, 4'd0, 1'b0);
    send_seq("t7a", 3, 16'b101, 16'b101);
    load(8'b10110011, 4'(PW + 3), 1'b1);
    send_seq("t7b", 10, 16'b1011001101, 16'b0000000100);

    // 8) counter saturation
    load(8'h01, 4'd1, 1'b1);
    send_seq("t8", 5, 16'b11111, 16'b11111);
    check("t8_cnt", int'(match_cnt), CNT_EN ? 3 : 0);

    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
